// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
// Single-port burst arbiter between the frame buffer's read/write burst
// channels and the DDR3 controller native command/data port. One burst is
// granted at a time: a command is issued, beats are steered in the granted
// direction, and the matching finish strobe pulses for one cycle.
//
// Handshake: the command is held (app_cmd_valid with stable fields) until
// the cycle where app_cmd_valid & app_cmd_ready are both high; that cycle is
// the transfer. Read beats pass through when app_rdata_valid is high; write
// beat requests are forwarded and the data follows one cycle later.
//
// Configuration macro: MEM_ARB_WR_PRIORITY_EN
//   defined   -> fixed write priority when both channels request
//   undefined -> round-robin using the last_wr flag (read wins first)
module mem_burst_arbiter #(
    parameter int MEM_DATA_BITS = 256,
    parameter int ADDR_BITS     = 25,
    parameter int BUSRT_BITS    = 10
) (
    input  logic                     mem_clk,
    input  logic                     rst,

    input  logic                     rd_burst_req,
    input  logic [BUSRT_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,

    input  logic                     wr_burst_req,
    input  logic [BUSRT_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,

    output logic                     app_cmd_valid,
    input  logic                     app_cmd_ready,
    output logic                     app_cmd_rw,
    output logic [ADDR_BITS-1:0]     app_cmd_addr,
    output logic [BUSRT_BITS-1:0]    app_cmd_len,
    input  logic                     app_wdata_req,
    output logic [MEM_DATA_BITS-1:0] app_wdata,
    input  logic                     app_rdata_valid,
    input  logic [MEM_DATA_BITS-1:0] app_rdata,

    output logic [2:0]               dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_CMD  = 3'd1,
        S_WR_CMD  = 3'd2,
        S_RD_DATA = 3'd3,
        S_WR_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [BUSRT_BITS:0] CNT_ONE = {{BUSRT_BITS{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    // One extra bit so the maximum length never wraps the counter
    logic [BUSRT_BITS:0]     cnt_q, cnt_d;
    logic [BUSRT_BITS-1:0]   len_q, len_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic                    rw_q, rw_d;       // 1 = read burst granted
`ifndef MEM_ARB_WR_PRIORITY_EN
    logic                    last_wr_q, last_wr_d;
`endif

    logic [BUSRT_BITS:0]     len_ext;
    logic                    grant_rd;
    logic                    wr_fwd;

    assign len_ext = {1'b0, len_q};

`ifdef MEM_ARB_WR_PRIORITY_EN
    // Write always wins a contested cycle
    assign grant_rd = rd_burst_req & ~wr_burst_req;
`else
    // Read wins a contested cycle only if the previous grant was a write
    assign grant_rd = rd_burst_req & (~wr_burst_req | last_wr_q);
`endif

    // Write beat request is forwarded only while beats remain to be asked for
    assign wr_fwd = (state_q == S_WR_DATA) & app_wdata_req & (cnt_q < len_ext);

    // Next-state, counter and grant-latch logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
`ifndef MEM_ARB_WR_PRIORITY_EN
        last_wr_d = last_wr_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_rd) begin
                    rw_d    = 1'b1;
                    len_d   = rd_burst_len;
                    addr_d  = rd_burst_addr;
                    state_d = S_RD_CMD;
`ifndef MEM_ARB_WR_PRIORITY_EN
                    last_wr_d = 1'b0;
`endif
                end else if (wr_burst_req) begin
                    rw_d    = 1'b0;
                    len_d   = wr_burst_len;
                    addr_d  = wr_burst_addr;
                    state_d = S_WR_CMD;
`ifndef MEM_ARB_WR_PRIORITY_EN
                    last_wr_d = 1'b1;
`endif
                end
            end
            S_RD_CMD: begin
                // Zero-length bursts never reach the controller
                if (len_q == '0) begin
                    state_d = S_DONE;
                end else if (app_cmd_ready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_WR_CMD: begin
                if (len_q == '0) begin
                    state_d = S_DONE;
                end else if (app_cmd_ready) begin
                    state_d = S_WR_DATA;
                end
            end
            S_RD_DATA: begin
                if (app_rdata_valid) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == len_ext) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WR_DATA: begin
                // Once all requests are out, this cycle carries the last data
                if (cnt_q == len_ext) begin
                    state_d = S_DONE;
                end else if (wr_fwd) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
`ifndef MEM_ARB_WR_PRIORITY_EN
            last_wr_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
`ifndef MEM_ARB_WR_PRIORITY_EN
            last_wr_q <= last_wr_d;
`endif
        end
    end

    assign app_cmd_valid = ((state_q == S_RD_CMD) | (state_q == S_WR_CMD)) & (len_q != '0);
    assign app_cmd_rw    = rw_q;
    assign app_cmd_addr  = addr_q;
    assign app_cmd_len   = len_q;

    // Beats outside the data states are dropped
    assign rd_burst_data_valid = (state_q == S_RD_DATA) & app_rdata_valid;
    assign rd_burst_data       = (state_q == S_RD_DATA) ? app_rdata : '0;
    assign wr_burst_data_req   = wr_fwd;
    assign app_wdata           = (state_q == S_WR_DATA) ? wr_burst_data : '0;

    assign rd_burst_finish = (state_q == S_DONE) &  rw_q;
    assign wr_burst_finish = (state_q == S_DONE) & ~rw_q;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Bench for mem_burst_arbiter: directed bursts, per-cycle comparison of all
// outputs against expectations derived from burst timing rules, plus literal
// counts and latencies for each scenario.
module tb_mem_burst_arbiter;

    localparam int DW = 256;
    localparam int AW = 25;
    localparam int LW = 10;

    // ---------------- clock / reset ----------------
    logic mem_clk = 1'b0;
    logic rst;
    always #5 mem_clk = ~mem_clk;

    logic          rd_burst_req, wr_burst_req;
    logic [LW-1:0] rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic          rd_burst_data_valid, rd_burst_finish;
    logic [DW-1:0] rd_burst_data;
    logic          wr_burst_data_req, wr_burst_finish;
    logic [DW-1:0] wr_burst_data;
    logic          app_cmd_valid, app_cmd_ready, app_cmd_rw;
    logic [AW-1:0] app_cmd_addr;
    logic [LW-1:0] app_cmd_len;
    logic          app_wdata_req, app_rdata_valid;
    logic [DW-1:0] app_wdata, app_rdata;
    logic [2:0]    dbg_state;

    mem_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BUSRT_BITS(LW)) dut (
        .mem_clk(mem_clk), .rst(rst),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish),
        .app_cmd_valid(app_cmd_valid), .app_cmd_ready(app_cmd_ready), .app_cmd_rw(app_cmd_rw),
        .app_cmd_addr(app_cmd_addr), .app_cmd_len(app_cmd_len),
        .app_wdata_req(app_wdata_req), .app_wdata(app_wdata),
        .app_rdata_valid(app_rdata_valid), .app_rdata(app_rdata),
        .dbg_state_o(dbg_state)
    );

    // ---------------- model expectations for the current cycle ----------------
    int            cyc;
    int            n_total, n_pass;
    bit            chk_en;
    bit            m_last_wr;
    logic          exp_cmd_valid, exp_cmd_rw, exp_zero;
    logic [AW-1:0] exp_cmd_addr;
    logic [LW-1:0] exp_cmd_len;
    logic          exp_rd_valid, exp_wr_dreq, exp_wdata_chk, exp_rd_fin, exp_wr_fin;
    logic [DW-1:0] exp_rd_data, exp_wdata;

    // observed activity
    int m_rd_beats, m_wr_dreq, m_rd_fin, m_wr_fin, m_cmd_valid;
    int m_last_rd_beat_cyc, m_last_dreq_cyc, m_last_rd_fin_cyc, m_last_wr_fin_cyc;
    logic grant_log[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- scoreboard: compare every cycle ----------------
    always @(negedge mem_clk) begin
        if (chk_en) begin
            chk("cmd_valid", app_cmd_valid, exp_cmd_valid);
            if (exp_cmd_valid) begin
                chk("cmd_rw", app_cmd_rw, exp_cmd_rw);
                chk("cmd_addr", app_cmd_addr, exp_cmd_addr);
                chk("cmd_len", app_cmd_len, exp_cmd_len);
            end
            if (exp_zero) begin
                chk("zero_cmd_rw", app_cmd_rw, 0);
                chk("zero_cmd_addr", app_cmd_addr, 0);
                chk("zero_cmd_len", app_cmd_len, 0);
                chk("zero_rd_data", rd_burst_data, 0);
                chk("zero_app_wdata", app_wdata, 0);
            end
            chk("rd_valid", rd_burst_data_valid, exp_rd_valid);
            if (exp_rd_valid) chk("rd_data", rd_burst_data, exp_rd_data);
            chk("wr_data_req", wr_burst_data_req, exp_wr_dreq);
            if (exp_wdata_chk) chk("app_wdata", app_wdata, exp_wdata);
            chk("rd_finish", rd_burst_finish, exp_rd_fin);
            chk("wr_finish", wr_burst_finish, exp_wr_fin);

            if (app_cmd_valid) m_cmd_valid++;
            if (rd_burst_data_valid) begin m_rd_beats++; m_last_rd_beat_cyc = cyc; end
            if (wr_burst_data_req) begin m_wr_dreq++; m_last_dreq_cyc = cyc; end
            if (rd_burst_finish) begin m_rd_fin++; m_last_rd_fin_cyc = cyc; grant_log.push_back(1'b1); end
            if (wr_burst_finish) begin m_wr_fin++; m_last_wr_fin_cyc = cyc; grant_log.push_back(1'b0); end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge mem_clk);
        #1;
        cyc++;
        exp_cmd_valid = 0; exp_cmd_rw = 0; exp_cmd_addr = '0; exp_cmd_len = '0; exp_zero = 0;
        exp_rd_valid = 0; exp_rd_data = '0; exp_wr_dreq = 0; exp_wdata_chk = 0; exp_wdata = '0;
        exp_rd_fin = 0; exp_wr_fin = 0;
        app_cmd_ready = 0; app_rdata_valid = 0; app_wdata_req = 0;
    endtask

    // Called in the IDLE cycle that grants this read; returns in its DONE cycle
    task automatic rd_phase(input logic [AW-1:0] a, input int len, input int stall, input bit gappy);
        int beats;
        int k;
        m_last_wr = 0;
        step();
        if (len == 0) begin
            app_cmd_ready = 1;
            step();
        end else begin
            for (int s = 0; s <= stall; s++) begin
                exp_cmd_valid = 1; exp_cmd_rw = 1; exp_cmd_addr = a; exp_cmd_len = LW'(len);
                app_cmd_ready = (s == stall);
                if (s != stall) begin app_rdata_valid = 1; app_wdata_req = 1; app_rdata = rnd(); end
                step();
            end
            beats = 0;
            k = 0;
            while (beats < len) begin
                app_rdata_valid = gappy ? ((k % 3) != 1) : 1'b1;
                app_rdata = rnd();
                exp_rd_valid = app_rdata_valid;
                exp_rd_data = app_rdata;
                if (app_rdata_valid) beats++;
                k++;
                step();
            end
        end
        exp_rd_fin = 1;
    endtask

    // Called in the IDLE cycle that grants this write; returns in its DONE cycle
    task automatic wr_phase(input logic [AW-1:0] a, input int len, input int stall, input bit toggle);
        int  reqs;
        int  k;
        bit  prev_fwd;
        bit  last;
        m_last_wr = 1;
        step();
        if (len == 0) begin
            app_cmd_ready = 1;
            step();
        end else begin
            for (int s = 0; s <= stall; s++) begin
                exp_cmd_valid = 1; exp_cmd_rw = 0; exp_cmd_addr = a; exp_cmd_len = LW'(len);
                app_cmd_ready = (s == stall);
                if (s != stall) begin app_rdata_valid = 1; app_wdata_req = 1; end
                step();
            end
            reqs = 0;
            k = 0;
            prev_fwd = 0;
            for (int g = 0; g < 4 * len + 8; g++) begin
                app_wdata_req = toggle ? ((k % 2) == 0) : 1'b1;
                k++;
                exp_wr_dreq = app_wdata_req && (reqs < len);
                if (prev_fwd) begin
                    wr_burst_data = rnd();
                    exp_wdata_chk = 1;
                    exp_wdata = wr_burst_data;
                end
                last = prev_fwd && (reqs == len);
                prev_fwd = exp_wr_dreq;
                if (exp_wr_dreq) reqs++;
                step();
                if (last) break;
            end
        end
        exp_wr_fin = 1;
    endtask

    // ---------------- main sequence ----------------
    int b_beats, b_dreq, b_rdfin, b_wrfin, b_cmd, b_log, req_cyc;
    logic [3:0] order;

    initial begin
        cyc = 0; n_total = 0; n_pass = 0; chk_en = 0; m_last_wr = 1;
        m_rd_beats = 0; m_wr_dreq = 0; m_rd_fin = 0; m_wr_fin = 0; m_cmd_valid = 0;
        m_last_rd_beat_cyc = 0; m_last_dreq_cyc = 0; m_last_rd_fin_cyc = 0; m_last_wr_fin_cyc = 0;
        rst = 1;
        rd_burst_req = 0; rd_burst_len = '0; rd_burst_addr = '0;
        wr_burst_req = 0; wr_burst_len = '0; wr_burst_addr = '0;
        wr_burst_data = '0; app_rdata = '0;
        app_cmd_ready = 0; app_rdata_valid = 0; app_wdata_req = 0;
        step();
        step();

        // Reset state, with spurious controller activity present
        chk_en = 1;
        exp_zero = 1;
        app_rdata_valid = 1; app_wdata_req = 1; app_rdata = rnd(); wr_burst_data = rnd();
        rst = 0;

        // Spurious controller beats in IDLE are dropped
        for (int i = 0; i < 4; i++) begin
            step();
            exp_zero = 1;
            app_rdata_valid = 1; app_wdata_req = (i % 2) == 0; app_rdata = rnd(); wr_burst_data = rnd();
        end
        step();

        // Read only, len 4, addr 0x100, ready stalled 3 cycles
        exp_zero = 1;
        b_beats = m_rd_beats; b_rdfin = m_rd_fin; b_cmd = m_cmd_valid;
        rd_burst_req = 1; rd_burst_len = 10'd4; rd_burst_addr = 25'h100;
        rd_phase(25'h100, 4, 3, 1'b1);
        rd_burst_req = 0; rd_burst_len = 10'd9; rd_burst_addr = 25'h7;
        step();
        chk("rd4_beats", m_rd_beats - b_beats, 4);
        chk("rd4_finish_count", m_rd_fin - b_rdfin, 1);
        chk("rd4_cmd_cycles", m_cmd_valid - b_cmd, 4);
        chk("rd4_finish_latency", m_last_rd_fin_cyc - m_last_rd_beat_cyc, 1);

        // Write only, len 8, app_wdata_req toggling
        b_dreq = m_wr_dreq; b_wrfin = m_wr_fin;
        wr_burst_req = 1; wr_burst_len = 10'd8; wr_burst_addr = 25'h1F00;
        wr_phase(25'h1F00, 8, 1, 1'b1);
        wr_burst_req = 0;
        step();
        chk("wr8_data_reqs", m_wr_dreq - b_dreq, 8);
        chk("wr8_finish_count", m_wr_fin - b_wrfin, 1);
        chk("wr8_finish_latency", m_last_wr_fin_cyc - m_last_dreq_cyc, 2);

        // Both requests held continuously, len 2 each
        b_log = grant_log.size();
        rd_burst_req = 1; rd_burst_len = 10'd2; rd_burst_addr = 25'h0AA;
        wr_burst_req = 1; wr_burst_len = 10'd2; wr_burst_addr = 25'h155;
`ifdef MEM_ARB_WR_PRIORITY_EN
        for (int i = 0; i < 3; i++) begin
            wr_phase(25'h155, 2, 0, 1'b0);
            if (i == 2) wr_burst_req = 0;
            step();
        end
        rd_phase(25'h0AA, 2, 0, 1'b0);
        rd_burst_req = 0;
        step();
        order = {1'b0, grant_log[b_log], grant_log[b_log+1], grant_log[b_log+2]};
        chk("grant_order_WWW", order, 4'b0000);
`else
        for (int i = 0; i < 4; i++) begin
            if (m_last_wr) rd_phase(25'h0AA, 2, 0, 1'b0);
            else wr_phase(25'h155, 2, 0, 1'b0);
            if (i == 3) begin rd_burst_req = 0; wr_burst_req = 0; end
            step();
        end
        order = {grant_log[b_log], grant_log[b_log+1], grant_log[b_log+2], grant_log[b_log+3]};
        chk("grant_order_RWRW", order, 4'b1010);
`endif

        // Zero-length write: no command, finish 2 cycles after the request
        b_cmd = m_cmd_valid; b_wrfin = m_wr_fin;
        req_cyc = cyc;
        wr_burst_req = 1; wr_burst_len = 10'd0; wr_burst_addr = 25'h55;
        wr_phase(25'h55, 0, 0, 1'b0);
        wr_burst_req = 0;
        step();
        chk("wr0_no_cmd", m_cmd_valid - b_cmd, 0);
        chk("wr0_finish_count", m_wr_fin - b_wrfin, 1);
        chk("wr0_finish_latency", m_last_wr_fin_cyc - req_cyc, 2);

        // Reset in the middle of a 16-beat read after 2 beats
        b_beats = m_rd_beats; b_rdfin = m_rd_fin;
        rd_burst_req = 1; rd_burst_len = 10'd16; rd_burst_addr = 25'h2A0;
        step();
        exp_cmd_valid = 1; exp_cmd_rw = 1; exp_cmd_addr = 25'h2A0; exp_cmd_len = 10'd16;
        app_cmd_ready = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            app_rdata_valid = 1; app_rdata = rnd();
            exp_rd_valid = 1; exp_rd_data = app_rdata;
            step();
        end
        rst = 1; rd_burst_req = 0;
        step();
        rst = 0;
        m_last_wr = 1;
        exp_zero = 1;
        app_rdata_valid = 1; app_wdata_req = 1; app_rdata = rnd(); wr_burst_data = rnd();
        step();
        exp_zero = 1;
        rd_burst_req = 1; rd_burst_len = 10'd1; rd_burst_addr = 25'h3C;
        rd_phase(25'h3C, 1, 0, 1'b0);
        rd_burst_req = 0;
        step();
        chk("rst_then_rd1_beats", m_rd_beats - b_beats, 3);
        chk("rst_then_rd1_finish_count", m_rd_fin - b_rdfin, 1);
        chk("rd1_finish_latency", m_last_rd_fin_cyc - m_last_rd_beat_cyc, 1);

        step();
        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
